// File: rtl/anabellek_paket.sv
// Shared definitions for the multi-word main-memory controller: FSM encoding, strobe constants, width helpers.
// Latency: none (declarations only).
// Backpressure: not applicable.
package anabellek_paket;

    typedef enum logic [1:0] {
        MUSAIT = 2'b00,
        YAZ    = 2'b01,
        OKU    = 2'b10
    } durum_t;

    // One strobe bit; replicated to the bus strobe width by the users.
    localparam logic STRB_BIT_ACIK   = 1'b1;
    localparam logic STRB_BIT_KAPALI = 1'b0;

    function automatic int obek_genisligi(input int veri_gen, input int kelime);
        return veri_gen * kelime;
    endfunction

    function automatic int strb_genisligi(input int veri_gen);
        return veri_gen / 8;
    endfunction

    function automatic int kelime_bit(input int kelime);
        return $clog2(kelime);
    endfunction

    function automatic int bayt_bit(input int veri_gen);
        return $clog2(veri_gen / 8);
    endfunction

endpackage

// File: rtl/anabellek_adres_uretici.sv
// Beat address generator: block base, wrapping word index, beat counter and last-beat flag.
// Latency: address valid the cycle after baslat_i; advances one word the cycle after ilerle_i.
// Backpressure: holds index and address while ilerle_i is low.
module anabellek_adres_uretici
    import anabellek_paket::*;
#(
    parameter int  ADRES_GENISLIGI = 32,
    parameter int  VERI_GENISLIGI  = 32,
    parameter int  OBEK_KELIME     = 4,
    localparam int KELIME_BIT      = kelime_bit(OBEK_KELIME),
    localparam int BAYT_BIT        = bayt_bit(VERI_GENISLIGI)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       baslat_i,
    input  logic                       ilerle_i,
    input  logic [ADRES_GENISLIGI-1:0] baslangic_adres_i,
    input  logic [KELIME_BIT-1:0]      baslangic_indeks_i,
    output logic [ADRES_GENISLIGI-1:0] adres_o,
    output logic [KELIME_BIT-1:0]      indeks_o,
    output logic [KELIME_BIT-1:0]      sonraki_indeks_o,
    output logic                       son_vurus_o
);

    // Clears the word-index and byte-offset bits so the burst stays inside one block.
    localparam logic [ADRES_GENISLIGI-1:0] TABAN_MASKE =
        ~((ADRES_GENISLIGI'(1) << (KELIME_BIT + BAYT_BIT)) - ADRES_GENISLIGI'(1));
    localparam logic [KELIME_BIT-1:0] SON_ONCESI = KELIME_BIT'(OBEK_KELIME - 2);

    logic [ADRES_GENISLIGI-1:0] taban_q, taban_d;
    logic [KELIME_BIT-1:0]      indeks_q, indeks_d;
    logic [KELIME_BIT-1:0]      sayac_q, sayac_d;
    logic                       son_q, son_d;

    // Load on a new request, step on an accepted beat; index wraps naturally at KELIME_BIT.
    always_comb begin
        taban_d  = taban_q;
        indeks_d = indeks_q;
        sayac_d  = sayac_q;
        son_d    = son_q;
        if (baslat_i) begin
            taban_d  = baslangic_adres_i & TABAN_MASKE;
            indeks_d = baslangic_indeks_i;
            sayac_d  = '0;
            son_d    = 1'b0;
        end else if (ilerle_i) begin
            indeks_d = indeks_q + KELIME_BIT'(1);
            sayac_d  = sayac_q + KELIME_BIT'(1);
            son_d    = (sayac_q == SON_ONCESI);
        end
    end

    // Generator registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            taban_q  <= '0;
            indeks_q <= '0;
            sayac_q  <= '0;
            son_q    <= 1'b0;
        end else begin
            taban_q  <= taban_d;
            indeks_q <= indeks_d;
            sayac_q  <= sayac_d;
            son_q    <= son_d;
        end
    end

    // Base and index occupy disjoint bits, so the address is pure wiring of registers.
    assign adres_o          = taban_q | (ADRES_GENISLIGI'(indeks_q) << BAYT_BIT);
    assign indeks_o         = indeks_q;
    assign sonraki_indeks_o = indeks_d;
    assign son_vurus_o      = son_q;

endmodule

// File: rtl/cok_kelimeli_anabellek_denetleyici.sv
// Main-memory controller moving one cache block as single-word iomem beats; optional critical word first (ANABELLEK_KRITIK_KELIME_ONCE_EN).
// Latency: first beat one cycle after acceptance, back-to-back beats, block done OBEK_KELIME+1 cycles after acceptance at zero wait.
// Backpressure: each beat's valid/address/data/strobe held until iomem_ready_i; new requests only while anabellek_musait_o.
module cok_kelimeli_anabellek_denetleyici
    import anabellek_paket::*;
#(
    parameter int  ADRES_GENISLIGI = 32,
    parameter int  VERI_GENISLIGI  = 32,
    parameter int  OBEK_KELIME     = 4,
    localparam int OBEK_GENISLIGI  = obek_genisligi(VERI_GENISLIGI, OBEK_KELIME),
    localparam int STRB            = strb_genisligi(VERI_GENISLIGI),
    localparam int KELIME_BIT      = kelime_bit(OBEK_KELIME)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       anabellege_istek_i,
    input  logic                       oku_i,
    input  logic                       yaz_i,
    input  logic [ADRES_GENISLIGI-1:0] oku_adres_i,
    input  logic [ADRES_GENISLIGI-1:0] yaz_adres_i,
    input  logic [OBEK_GENISLIGI-1:0]  yaz_veri_obegi_i,
    input  logic                       iomem_ready_i,
    input  logic [VERI_GENISLIGI-1:0]  anabellekten_veri_i,
    output logic [ADRES_GENISLIGI-1:0] adres_o,
    output logic [VERI_GENISLIGI-1:0]  yaz_veri_o,
    output logic                       iomem_valid_o,
    output logic [STRB-1:0]            wr_strb_o,
    output logic                       anabellek_musait_o,
    output logic                       okunan_veri_obegi_hazir_o,
    output logic [OBEK_GENISLIGI-1:0]  okunan_veri_obegi_o,
    output logic [VERI_GENISLIGI-1:0]  kritik_kelime_o,
    output logic                       kritik_kelime_hazir_o
);

    localparam int W = VERI_GENISLIGI;

    durum_t durum_q, durum_d;

    logic                  kabul, ilerle, son_vurus;
    logic [KELIME_BIT-1:0] indeks, sonraki_indeks, baslangic_indeks;

    logic [OBEK_GENISLIGI-1:0] yaz_tampon_q, yaz_tampon_d;
    logic [OBEK_GENISLIGI-1:0] oku_tampon_q, oku_tampon_d;
    logic [OBEK_GENISLIGI-1:0] obek_q, obek_d;
    logic                      obek_hazir_q, obek_hazir_d;
    logic [W-1:0]              yaz_veri_q, yaz_veri_d;
    logic                      valid_q, valid_d;
    logic                      musait_q, musait_d;
    logic [STRB-1:0]           strb_q, strb_d;

    // iomem_ready_i only matters while a burst is running.
    assign kabul  = (durum_q == MUSAIT) && anabellege_istek_i && (oku_i || yaz_i);
    assign ilerle = (durum_q != MUSAIT) && iomem_ready_i;

`ifdef ANABELLEK_KRITIK_KELIME_ONCE_EN
    assign baslangic_indeks = oku_i ? oku_adres_i[bayt_bit(VERI_GENISLIGI) +: KELIME_BIT] : '0;
`else
    assign baslangic_indeks = '0;
`endif

    anabellek_adres_uretici #(
        .ADRES_GENISLIGI (ADRES_GENISLIGI),
        .VERI_GENISLIGI  (VERI_GENISLIGI),
        .OBEK_KELIME     (OBEK_KELIME)
    ) u_adres_uretici (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .baslat_i           (kabul),
        .ilerle_i           (ilerle),
        .baslangic_adres_i  (oku_i ? oku_adres_i : yaz_adres_i),
        .baslangic_indeks_i (baslangic_indeks),
        .adres_o            (adres_o),
        .indeks_o           (indeks),
        .sonraki_indeks_o   (sonraki_indeks),
        .son_vurus_o        (son_vurus)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) durum_q <= MUSAIT;
        else        durum_q <= durum_d;
    end

    // Next state: read wins over write; return to idle once the last beat is accepted.
    always_comb begin
        durum_d = durum_q;
        case (durum_q)
            MUSAIT: begin
                if (anabellege_istek_i && oku_i)      durum_d = OKU;
                else if (anabellege_istek_i && yaz_i) durum_d = YAZ;
            end
            YAZ, OKU: begin
                if (iomem_ready_i && son_vurus) durum_d = MUSAIT;
            end
            default: durum_d = MUSAIT;
        endcase
    end

    // Next values of the bus control outputs, decoded from the upcoming state so they register cleanly.
    always_comb begin
        valid_d  = (durum_d != MUSAIT);
        musait_d = (durum_d == MUSAIT);
        strb_d   = (durum_d == YAZ) ? {STRB{STRB_BIT_ACIK}} : {STRB{STRB_BIT_KAPALI}};
    end

    // Datapath: latch the write block at acceptance, pick the next write word, merge read words by index.
    always_comb begin
        yaz_tampon_d = kabul ? yaz_veri_obegi_i : yaz_tampon_q;
        yaz_veri_d   = yaz_veri_q;
        if (kabul && !oku_i)
            yaz_veri_d = yaz_veri_obegi_i[W-1:0];
        else if ((durum_q == YAZ) && ilerle)
            yaz_veri_d = yaz_tampon_q[sonraki_indeks*W +: W];

        oku_tampon_d = oku_tampon_q;
        obek_d       = obek_q;
        obek_hazir_d = 1'b0;
        if ((durum_q == OKU) && ilerle) begin
            oku_tampon_d[indeks*W +: W] = anabellekten_veri_i;
            if (son_vurus) begin
                obek_d       = oku_tampon_d;
                obek_hazir_d = 1'b1;
            end
        end
    end

    // Output and buffer registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_q      <= 1'b0;
            musait_q     <= 1'b1;
            strb_q       <= '0;
            yaz_veri_q   <= '0;
            yaz_tampon_q <= '0;
            oku_tampon_q <= '0;
            obek_q       <= '0;
            obek_hazir_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            musait_q     <= musait_d;
            strb_q       <= strb_d;
            yaz_veri_q   <= yaz_veri_d;
            yaz_tampon_q <= yaz_tampon_d;
            oku_tampon_q <= oku_tampon_d;
            obek_q       <= obek_d;
            obek_hazir_q <= obek_hazir_d;
        end
    end

    assign iomem_valid_o             = valid_q;
    assign anabellek_musait_o        = musait_q;
    assign wr_strb_o                 = strb_q;
    assign yaz_veri_o                = yaz_veri_q;
    assign okunan_veri_obegi_o       = obek_q;
    assign okunan_veri_obegi_hazir_o = obek_hazir_q;

`ifdef ANABELLEK_KRITIK_KELIME_ONCE_EN
    logic         ilk_q, ilk_d;
    logic [W-1:0] kritik_q, kritik_d;
    logic         kritik_hazir_q, kritik_hazir_d;

    // The first accepted read beat is the requested word; forward it ahead of the block.
    always_comb begin
        ilk_d          = ilk_q;
        kritik_d       = kritik_q;
        kritik_hazir_d = 1'b0;
        if (kabul) begin
            ilk_d = oku_i;
        end else if ((durum_q == OKU) && ilerle) begin
            ilk_d = 1'b0;
            if (ilk_q) begin
                kritik_d       = anabellekten_veri_i;
                kritik_hazir_d = 1'b1;
            end
        end
    end

    // Critical word registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ilk_q          <= 1'b0;
            kritik_q       <= '0;
            kritik_hazir_q <= 1'b0;
        end else begin
            ilk_q          <= ilk_d;
            kritik_q       <= kritik_d;
            kritik_hazir_q <= kritik_hazir_d;
        end
    end

    assign kritik_kelime_o       = kritik_q;
    assign kritik_kelime_hazir_o = kritik_hazir_q;
`else
    assign kritik_kelime_o       = '0;
    assign kritik_kelime_hazir_o = 1'b0;
`endif

endmodule

// File: doc/cok_kelimeli_anabellek_denetleyici.md
# cok_kelimeli_anabellek_denetleyici

Parametrised main-memory controller between the cache controllers and the iomem-style memory bus. It moves one cache block of `OBEK_KELIME` words per request, as single-word iomem beats. It captures write data at request acceptance and places read words by address, so block width, word width and burst length are all configurable. It can also return the critical word first and signal it ahead of the full block.

## Interface
Parameters:
- `ADRES_GENISLIGI`, 32, byte address width.
- `VERI_GENISLIGI`, 32, bus word width; must be a multiple of 8.
- `OBEK_KELIME`, 4, words per block; must be a power of two and ≥2.
- Derived values: `OBEK_GENISLIGI` = `VERI_GENISLIGI`×`OBEK_KELIME`; `STRB` = `VERI_GENISLIGI`/8; `KELIME_BIT` = clog2(`OBEK_KELIME`); `BAYT_BIT` = clog2(`STRB`).

Ports:
- `clk_i`  in  1  single clock, rising edge.
- `rst_i`  in  1  synchronous, active-low reset.
- `anabellege_istek_i`  in  1  request strobe; sampled only while `anabellek_musait_o`=1.
- `oku_i` / `yaz_i`  in  1  read / write select; `oku_i` wins if both are set.
- `oku_adres_i`  in  `ADRES_GENISLIGI`  read byte address.
- `yaz_adres_i`  in  `ADRES_GENISLIGI`  write byte address; low bits are ignored and the block is aligned.
- `yaz_veri_obegi_i`  in  `OBEK_GENISLIGI`  write block; word i is bits [i·W +: W].
- `iomem_ready_i`  in  1  beat accepted or read data valid.
- `anabellekten_veri_i`  in  `VERI_GENISLIGI`  read data.
- `adres_o`  out  `ADRES_GENISLIGI`  beat byte address, always word-aligned.
- `yaz_veri_o`  out  `VERI_GENISLIGI`  beat write data.
- `iomem_valid_o`  out  1  beat request.
- `wr_strb_o`  out  `STRB`  all ones on write beats, zero on read beats.
- `anabellek_musait_o`  out  1  idle and able to accept a request.
- `okunan_veri_obegi_hazir_o`  out  1  one-cycle pulse: read block complete.
- `okunan_veri_obegi_o`  out  `OBEK_GENISLIGI`  assembled read block; held until the next read completes.
- `kritik_kelime_o`  out  `VERI_GENISLIGI`  first returned read word.
- `kritik_kelime_hazir_o`  out  1  one-cycle pulse: critical word valid.

## Operation
States are MUSAIT, OKU and YAZ.
- **MUSAIT → OKU/YAZ** on `anabellege_istek_i`·(`oku_i`|`yaz_i`).
  - At acceptance the controller latches the start address and, for writes, the whole `yaz_veri_obegi_i`. Inputs may change afterwards.
  - A request with neither `oku_i` nor `yaz_i` set is ignored.
- **Beat counter** `KELIME_BIT` wide, counts 0..`OBEK_KELIME`-1.
  - Beat word index = (start index + counter) mod `OBEK_KELIME`.
  - `adres_o` = {block base, index, `BAYT_BIT` zeros}. The address wraps inside the block and never crosses its boundary.
- **YAZ**
  - Beat k drives word[index] on `yaz_veri_o`.
  - On `iomem_ready_i` the controller advances; after the last beat it returns to MUSAIT.
  - A write always starts at index 0.
- **OKU**
  - On `iomem_ready_i`, `anabellekten_veri_i` is stored into block word[index]. Placement depends only on address, never on arrival order.
  - On the last beat `okunan_veri_obegi_o` updates and the hazir pulse is raised, then the FSM returns to MUSAIT.
- **Block integrity:** `okunan_veri_obegi_o` changes only at completion and never shows a partial block.
- **Reset mid-burst:** all state is discarded and the FSM goes to MUSAIT. No further beats are issued.

## Timing
- Reset values:
  - `iomem_valid_o`, `wr_strb_o`, `adres_o`, `yaz_veri_o` = 0.
  - `okunan_veri_obegi_o`, `kritik_kelime_o` = 0.
  - Both hazir pulses = 0.
  - `anabellek_musait_o` = 1.
- All outputs are registered.
- Acceptance in cycle t gives `iomem_valid_o`=1 and `anabellek_musait_o`=0 in t+1.
- `iomem_valid_o`, `adres_o`, `yaz_veri_o` and `wr_strb_o` are held stable until `iomem_ready_i`.
- With ready in cycle c:
  - If more beats remain, the next beat is presented in c+1 with valid still 1. This gives back-to-back beats and a minimum of `OBEK_KELIME`+1 cycles per block.
  - On the last beat, c+1 has `iomem_valid_o`=0, `anabellek_musait_o`=1, and for reads `okunan_veri_obegi_hazir_o`=1.
- A new request may be accepted in c+1, with its first beat in c+2.
- `iomem_ready_i` is ignored while in MUSAIT.

## Configuration
Macro: `ANABELLEK_KRITIK_KELIME_ONCE_EN`.
- **Defined:**
  - A read starts at index = `oku_adres_i`[`BAYT_BIT` +: `KELIME_BIT`].
  - After the first read beat, `kritik_kelime_o` takes the returned word and `kritik_kelime_hazir_o` pulses in the following cycle.
- **Undefined:**
  - A read starts at index 0.
  - `kritik_kelime_o` and `kritik_kelime_hazir_o` are tied to 0.
- Writes are identical in both cases.

## Structure
- Package `anabellek_paket` holds:
  - the state encoding (MUSAIT=2'b00, YAZ=2'b01, OKU=2'b10);
  - the strobe constants (all ones / zero);
  - the width-derivation functions.
- Sub-module `anabellek_adres_uretici` holds the beat counter, start-index latch, wrap logic and last-beat flag.
- The FSM, block buffers and output registers stay in the top module.

## Test plan
- **Write, zero-wait:** ready held at 1, default parameters, write 0x100 with block 0xDDDD…_CCCC…_BBBB…_AAAA…
  - Addresses 0x100, 0x104, 0x108, 0x10C carry AAAA, BBBB, CCCC, DDDD.
  - `wr_strb_o`=4'hF throughout; `anabellek_musait_o`=1 five cycles after acceptance.
- **Write data capture:** change `yaz_veri_obegi_i` the cycle after acceptance and insert 2-cycle ready stalls.
  - The original words are still emitted and the bus outputs stay stable during the stalls.
- **Critical-word read (macro on):** read 0x208; memory returns 11, 22, 33, 44.
  - Addresses 0x208, 0x20C, 0x200, 0x204.
  - `kritik_kelime_o`=11; final block = {22, 11, 44, 33} (word3..word0).
- **Aligned read (macro off):** same read of 0x208.
  - Addresses start at 0x200; kritik outputs stay 0; the hazir pulse lasts exactly one cycle.
- **Simultaneous select and back-to-back:** `oku_i`=`yaz_i`=1 → a read is performed.
  - A write request in the completion cycle is accepted, and its first beat appears in c+2.
- **Reset and parameters:** drop `rst_i` during beat 2 of a read.
  - Next cycle: valid=0, musait=1, obek=0.
  - Repeat the read/write directed cases at `VERI_GENISLIGI`=64, `OBEK_KELIME`=8; addresses step by 8.
